// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO port responder: default window base and the
// register map, used by the processor top-level decode and software headers.
package mmio_pkg;

  localparam logic [31:0] MMIO_BASE_ADDR = 32'h1001_0040;

  localparam logic [1:0] OFF_PORT_OUT = 2'd0;
  localparam logic [1:0] OFF_PORT_IN  = 2'd1;
  localparam logic [1:0] OFF_STATUS   = 2'd2;
  localparam logic [1:0] OFF_CAPTURE  = 2'd3;

  localparam int CHG_BIT = 0;

endpackage

// File: rtl/bit_synchronizer.sv
// Parameterized-width two-flop synchronizer for asynchronous input pins.
module bit_synchronizer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mmio_port_responder.sv
// Single-cycle MMIO responder: PORT_OUT register, synchronized PORT_IN view,
// sticky input-change flag (W1C) and the input value captured at the last change.
module mmio_port_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = MMIO_BASE_ADDR,
  parameter int          IN_WIDTH  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Address,
  input  logic [31:0]         WriteData,
  input  logic                MemWrite,
  input  logic                MemRead,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         ReadData,
  output logic                io_hit,
  output logic [31:0]         PortOut
);

  logic [31:0]         port_out_q, port_out_d;
  logic [IN_WIDTH-1:0] in_prev_q,  in_prev_d;
  logic                chg_q,      chg_d;
  logic [IN_WIDTH-1:0] capture_q,  capture_d;

  logic [IN_WIDTH-1:0] in_sync;
  logic [1:0]          reg_sel;
  logic                wr_en;
  logic                chg_det;
  logic [31:0]         in_sync_ext;
  logic [31:0]         capture_ext;
  logic [31:0]         rd_sel;

  bit_synchronizer #(
    .WIDTH (IN_WIDTH)
  ) u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d_i   (PortIn),
    .q_o   (in_sync)
  );

  // Unaligned addresses inside the window are deliberately not hits.
  assign io_hit  = (Address[31:4] == BASE_ADDR[31:4]) && (Address[1:0] == 2'b00);
  assign reg_sel = Address[3:2];
  assign wr_en   = MemWrite && io_hit;
  assign chg_det = (in_sync != in_prev_q);

  always_comb begin
    in_sync_ext                 = '0;
    capture_ext                 = '0;
    in_sync_ext[IN_WIDTH-1:0]   = in_sync;
    capture_ext[IN_WIDTH-1:0]   = capture_q;
  end

  always_comb begin
    port_out_d = port_out_q;
    chg_d      = chg_q;
    capture_d  = capture_q;
    in_prev_d  = in_sync;

    if (wr_en && (reg_sel == OFF_PORT_OUT)) begin
      port_out_d = WriteData;
    end
    if (wr_en && (reg_sel == OFF_STATUS) && WriteData[CHG_BIT]) begin
      chg_d = 1'b0;
    end
    // A change on the same edge as a W1C clear keeps the flag set.
    if (chg_det) begin
      chg_d     = 1'b1;
      capture_d = in_sync;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      port_out_q <= '0;
      in_prev_q  <= '0;
      chg_q      <= 1'b0;
      capture_q  <= '0;
    end else begin
      port_out_q <= port_out_d;
      in_prev_q  <= in_prev_d;
      chg_q      <= chg_d;
      capture_q  <= capture_d;
    end
  end

  always_comb begin
    rd_sel = '0;
    case (reg_sel)
      OFF_PORT_OUT: rd_sel = port_out_q;
      OFF_PORT_IN:  rd_sel = in_sync_ext;
      OFF_STATUS:   rd_sel[CHG_BIT] = chg_q;
      OFF_CAPTURE:  rd_sel = capture_ext;
      default:      rd_sel = '0;
    endcase
    ReadData = (MemRead && io_hit) ? rd_sel : 32'h0;
  end

  assign PortOut = port_out_q;

endmodule

// File: tb/tb_mmio_port_responder.sv
// Scoreboard bench for mmio_port_responder: directed scenarios then random traffic.
`timescale 1ns/1ps
module tb_mmio_port_responder;

  localparam logic [31:0] BASE = 32'h1001_0040;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [7:0]  PortIn;
  logic [31:0] ReadData;
  logic        io_hit;
  logic [31:0] PortOut;

  always #5 clk = ~clk;

  mmio_port_responder #(
    .BASE_ADDR (BASE),
    .IN_WIDTH  (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (Address),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .PortIn    (PortIn),
    .ReadData  (ReadData),
    .io_hit    (io_hit),
    .PortOut   (PortOut)
  );

  typedef struct packed {
    logic [31:0] rd;
    logic [31:0] po;
    logic        hit;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: pin samples taken at each clock edge, newest first.
  // The value visible as in_sync is the sample from two edges back.
  logic [31:0] m_po;
  logic        m_chg;
  logic [7:0]  m_cap;
  logic [7:0]  hist[$];

  function automatic logic m_hit(input logic [31:0] a);
    return (a[31:4] == BASE[31:4]) && (a[1:0] == 2'b00);
  endfunction

  task automatic model_reset();
    m_po  = 32'h0;
    m_chg = 1'b0;
    m_cap = 8'h0;
    hist  = '{8'h00, 8'h00, 8'h00};
  endtask

  task automatic model_edge();
    logic       det;
    logic [7:0] seen;
    if (!reset) return;
    seen = hist[1];
    det  = (hist[1] != hist[2]);
    if (MemWrite && m_hit(Address)) begin
      if (Address[3:2] == 2'd0) m_po = WriteData;
      if (Address[3:2] == 2'd2 && WriteData[0]) m_chg = 1'b0;
    end
    if (det) begin
      m_chg = 1'b1;
      m_cap = seen;
    end
    hist.push_front(PortIn);
    void'(hist.pop_back());
  endtask

  function automatic logic [31:0] m_read();
    if (!(MemRead && m_hit(Address))) return 32'h0;
    case (Address[3:2])
      2'd0:    return m_po;
      2'd1:    return {24'h0, hist[1]};
      2'd2:    return {31'h0, m_chg};
      default: return {24'h0, m_cap};
    endcase
  endfunction

  task automatic cyc(input logic [31:0] a, input logic [31:0] wd, input logic mw,
                     input logic mr, input logic [7:0] pin, input logic rn);
    exp_t e;
    @(posedge clk);
    #1;
    model_edge();
    Address   = a;
    WriteData = wd;
    MemWrite  = mw;
    MemRead   = mr;
    PortIn    = pin;
    reset     = rn;
    if (!rn) model_reset();
    e.rd  = m_read();
    e.po  = m_po;
    e.hit = m_hit(a);
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (ReadData !== e.rd) begin
        errors++;
        $display("FAIL ReadData @%0t addr=%h: got %h expected %h", $time, Address, ReadData, e.rd);
      end
      checks++;
      if (PortOut !== e.po) begin
        errors++;
        $display("FAIL PortOut @%0t: got %h expected %h", $time, PortOut, e.po);
      end
      checks++;
      if (io_hit !== e.hit) begin
        errors++;
        $display("FAIL io_hit @%0t addr=%h: got %b expected %b", $time, Address, io_hit, e.hit);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0]  pin;
    logic [31:0] a;
    Address = BASE + 32'h4; WriteData = 0; MemWrite = 0; MemRead = 1;
    PortIn = 8'hA5; reset = 1'b0;
    model_reset();

    // Reset held with pins active and clocks running.
    for (int i = 0; i < 3; i++) cyc(BASE + 32'h4, 32'h0, 1'b0, 1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 4; i++) cyc(BASE + 32'(4 * i), 32'hFFFF_FFFF, 1'b1, 1'b1, 8'hA5, 1'b0);

    // Store and read back; write to PORT_IN ignored.
    cyc(BASE, 32'h0, 1'b0, 1'b1, 8'h00, 1'b1);
    cyc(BASE, 32'hDEAD_BEEF, 1'b1, 1'b1, 8'h00, 1'b1);
    cyc(BASE, 32'h0, 1'b0, 1'b1, 8'h00, 1'b1);
    cyc(BASE + 32'h4, 32'h1234_5678, 1'b1, 1'b1, 8'h00, 1'b1);
    cyc(BASE + 32'h4, 32'h0, 1'b0, 1'b1, 8'h00, 1'b1);

    // Input change 0x00 -> 0x3C, then watch PORT_IN/STATUS/CAPTURE.
    cyc(BASE + 32'h4, 32'h0, 1'b0, 1'b1, 8'h3C, 1'b1);
    cyc(BASE + 32'h4, 32'h0, 1'b0, 1'b1, 8'h3C, 1'b1);
    cyc(BASE + 32'h8, 32'h0, 1'b0, 1'b1, 8'h3C, 1'b1);
    cyc(BASE + 32'h8, 32'h0, 1'b0, 1'b1, 8'h3C, 1'b1);
    cyc(BASE + 32'hC, 32'h0, 1'b0, 1'b1, 8'h3C, 1'b1);

    // W1C collides with the 0x3C -> 0x81 change detection.
    cyc(BASE + 32'h8, 32'h0, 1'b0, 1'b1, 8'h81, 1'b1);
    cyc(BASE + 32'h8, 32'h0, 1'b0, 1'b1, 8'h81, 1'b1);
    cyc(BASE + 32'h8, 32'h1, 1'b1, 1'b1, 8'h81, 1'b1);
    cyc(BASE + 32'h8, 32'h0, 1'b0, 1'b1, 8'h81, 1'b1);
    cyc(BASE + 32'hC, 32'h0, 1'b0, 1'b1, 8'h81, 1'b1);
    cyc(BASE + 32'h8, 32'h1, 1'b1, 1'b1, 8'h81, 1'b1);
    cyc(BASE + 32'h8, 32'h0, 1'b0, 1'b1, 8'h81, 1'b1);

    // Decode rejection.
    cyc(BASE + 32'h2, 32'h5555_AAAA, 1'b1, 1'b1, 8'h81, 1'b1);
    cyc(32'h1001_0050, 32'h6666_7777, 1'b1, 1'b1, 8'h81, 1'b1);
    cyc(BASE, 32'h0, 1'b0, 1'b0, 8'h81, 1'b1);
    cyc(BASE, 32'h0, 1'b0, 1'b1, 8'h81, 1'b1);

    // Async reset mid-operation with PortOut and CHG set.
    cyc(BASE, 32'h0000_1234, 1'b1, 1'b0, 8'h18, 1'b1);
    cyc(BASE + 32'h8, 32'h0, 1'b0, 1'b1, 8'h18, 1'b1);
    cyc(BASE + 32'h8, 32'h0, 1'b0, 1'b1, 8'h18, 1'b1);
    cyc(BASE + 32'h8, 32'h0, 1'b0, 1'b1, 8'h18, 1'b1);
    cyc(BASE + 32'h8, 32'h0, 1'b0, 1'b1, 8'h18, 1'b0);
    cyc(BASE, 32'h0, 1'b0, 1'b1, 8'h18, 1'b1);
    cyc(BASE + 32'h8, 32'h0, 1'b0, 1'b1, 8'h18, 1'b1);

    // Random traffic around and inside the window.
    pin = 8'h18;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) a = BASE + 32'($urandom_range(0, 15));
      else a = BASE - 32'h20 + 32'($urandom_range(0, 79));
      if ($urandom_range(0, 3) == 0) pin = 8'($urandom);
      cyc(a, $urandom, 1'($urandom), 1'($urandom_range(0, 3) != 0), pin,
          ($urandom_range(0, 63) != 0));
    end
    cyc(BASE + 32'h8, 32'h0, 1'b0, 1'b1, pin, 1'b1);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmio_port_responder.md
# mmio_port_responder

Memory-mapped I/O responder on the processor's data-memory bus: the peripheral that answers the processor's load/store accesses inside a fixed address window. It owns the 32-bit PortOut register, a synchronized view of the 8-bit PortIn pins, and a sticky input-change flag with a capture register. It sits beside DataMemory. The top level uses its `io_hit` output to steer load data between RAM and this block, and to suppress the RAM write.

## Interface
- `BASE_ADDR`, default 32'h1001_0040: byte address of register 0. Must be 16-byte aligned.
- `IN_WIDTH`, default 8: width of PortIn.
- `clk` input 1: single system clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low; clears all state immediately.
- `Address` input 32: byte address from the ALU result.
- `WriteData` input 32: store data (rt value).
- `MemWrite` input 1: store strobe, sampled at the rising edge of `clk`.
- `MemRead` input 1: load strobe, qualifies `ReadData`.
- `PortIn` input IN_WIDTH: asynchronous external pins.
- `ReadData` output 32: load data, combinational from registered state.
- `io_hit` output 1: high when `Address` decodes to this block (independent of the strobes).
- `PortOut` output 32: the PORT_OUT register.

## Operation
- Decode:
  - `io_hit` = (Address[31:4] == BASE_ADDR[31:4]) && (Address[1:0] == 2'b00).
  - Unaligned accesses are not hits and are ignored.
  - Register select is Address[3:2].
- Register map (offset: name, access):
  - 0x0 PORT_OUT, RW: a write loads all 32 bits of WriteData; a read returns the current value.
  - 0x4 PORT_IN, RO: {zeros, in_sync}. Writes are ignored.
  - 0x8 STATUS, R/W1C: bit0 = CHG (sticky change flag); bits 31:1 read 0. Writing WriteData[0]=1 clears CHG; writing 0 has no effect.
  - 0xC CAPTURE, RO: {zeros, in_sync value at the most recent change}. Writes are ignored.
- Input path:
  - PortIn passes through a two-flop synchronizer to `in_sync`.
  - A third register `in_prev` holds `in_sync` delayed by one cycle.
  - A change is defined as `chg_det` = (in_sync != in_prev).
- On each edge where `chg_det` is high: CHG <= 1 and CAPTURE <= in_sync.
- If a change is detected and a W1C write to STATUS occur in the same cycle, the set wins: CHG = 1 and CAPTURE is updated.
- `ReadData` is {32{MemRead && io_hit}} & selected register. It is 0 when not selected.
- Writes take effect only when MemWrite && io_hit at the clock edge. Writes with MemWrite high outside the window are ignored.
- No wait states. Every access completes in the cycle it is presented, matching the single-cycle datapath.

## Timing
- Reset values: PortOut = 0, both sync stages = 0, in_prev = 0, CHG = 0, CAPTURE = 0. Consequently `ReadData` = 0 for every register while in reset.
- Asserting `reset` mid-operation clears all state within the same cycle, with no clock required. The first access after deassertion sees reset values.
- Store to PORT_OUT presented in cycle n: PortOut shows the new value after edge n. A load from PORT_OUT in cycle n returns the old value.
- PortIn change settled before edge k:
  - Sync stage 1 captures it at edge k.
  - in_sync, and a PORT_IN read, shows it after edge k+1.
  - CHG = 1 and CAPTURE are updated after edge k+2.
- Total latency from pin to flag: 3 edges.
- Pulses shorter than one clock period may be missed. This is not a requirement.
- A PortIn value that toggles and returns before being sampled produces no change.
- W1C clear in cycle n: CHG reads 0 from cycle n+1, unless a change is detected in cycle n.

## Structure
- Shared package `mmio_pkg`:
  - Register offset constants OFF_PORT_OUT = 2'd0, OFF_PORT_IN = 2'd1, OFF_STATUS = 2'd2, OFF_CAPTURE = 2'd3.
  - STATUS bit index CHG_BIT = 0.
  - The default base address, so that the processor top-level decode and software headers use the same values.
- One sub-module: `bit_synchronizer`, a parameterized-width two-flop synchronizer with asynchronous active-low reset.
- Everything else (decoder, registers, read mux) lives in this module.

## Test plan
- Reset: hold reset low with PortIn = 8'hA5 and clocks running. Then PortOut = 0, and reads of all four offsets = 0 (MemRead = 1, Address = 0x1001_0044).
- Store and read back: write 32'hDEAD_BEEF to 0x1001_0040 → PortOut = DEAD_BEEF after the edge; a load in the same cycle returns the old value 0, and the next load returns DEAD_BEEF. Then write to 0x1001_0044 → PORT_IN is unchanged and PortOut is unchanged.
- Input change: PortIn 0x00 → 0x3C before edge k → PORT_IN = 0x3C after k+1; STATUS = 1 and CAPTURE = 0x3C after k+2.
- W1C collision: with CHG = 1, write 1 to STATUS in the same cycle as a new change 0x3C → 0x81 is detected → CHG remains 1 and CAPTURE = 0x81. A subsequent W1C with no change → STATUS = 0.
- Decode rejection:
  - Write to 0x1001_0042 (unaligned) → no effect, io_hit = 0.
  - Write to 0x1001_0050 → no effect, io_hit = 0.
  - Load at 0x1001_0040 with MemRead = 0 → ReadData = 0.
- Async reset mid-operation: set PortOut = 0x1234 and CHG = 1, then pulse reset low between clock edges → PortOut = 0 and STATUS = 0 immediately, before the next edge.
